dht11_emulador: RTL and testbench

Emulates the sensor side of the DHT11 single-wire protocol on an open-drain `dht_bus`, answering the host start pulse issued by the `dht11` interface block. Serves two purposes:
- loopback target for bench and on-board self-test of the measurement path (`dht11` → comparators → `transmissao_medida`) without a physical sensor;
- frame content comes from programmable humidity and temperature registers.

---
 rtl/dht11_emulador.sv | 171 +++++++++++++++++
 tb/tb_dht11_emulador.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_emulador.sv
// Sensor-side DHT11 emulator: answers a host start pulse on an open-drain line with a 40-bit frame.
// Optional DHT11_EMU_ERRO_CHECKSUM_EN adds corrompe_checksum, which flips the checksum LSB.
module dht11_emulador #(
  parameter int unsigned CICLOS_US  = 50,
  parameter int unsigned T_START_US = 18000,
  parameter int unsigned T_BIT0_US  = 26,
  parameter int unsigned T_BIT1_US  = 70
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire         dht_bus,
  input  logic [15:0] umidade,
  input  logic [15:0] temperatura,
  input  logic        habilita,
`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
  input  logic        corrompe_checksum,
`endif
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  localparam int unsigned N_START  = T_START_US * CICLOS_US;
  localparam int unsigned N_ATRASO = 30 * CICLOS_US;
  localparam int unsigned N_RESP   = 80 * CICLOS_US;
  localparam int unsigned N_BAIXO  = 50 * CICLOS_US;
  localparam int unsigned N_BIT0   = T_BIT0_US * CICLOS_US;
  localparam int unsigned N_BIT1   = T_BIT1_US * CICLOS_US;
  localparam int unsigned N_MAX_A  = (N_START > N_RESP) ? N_START : N_RESP;
  localparam int unsigned N_MAX    = (N_MAX_A > N_BIT1) ? N_MAX_A : N_BIT1;
  localparam int unsigned CONT_W   = $clog2(N_MAX + 1);
  localparam int unsigned QUADRO_W = 40;
  localparam int unsigned NBITS_W  = 6;

  typedef enum logic [3:0] {
    OCIOSO     = 4'd0,
    MEDE_START = 4'd1,
    ATRASO     = 4'd2,
    RESP_BAIXO = 4'd3,
    RESP_ALTO  = 4'd4,
    BIT_BAIXO  = 4'd5,
    BIT_ALTO   = 4'd6,
    FIM_BAIXO  = 4'd7,
    FIM        = 4'd8
  } estado_t;

  estado_t               r_estado;
  estado_t               w_estado_prox;
  logic                  r_sync1;
  logic                  r_bus_s;
  logic [CONT_W-1:0]     r_cont;
  logic [CONT_W-1:0]     w_dur_m1;
  logic [QUADRO_W-1:0]   r_shift;
  logic [NBITS_W-1:0]    r_nbits;
  logic                  r_puxa_baixo;
  logic                  r_ocupado;
  logic                  r_pronto;
  logic                  w_puxa_prox;
  logic                  w_ocupado_prox;
  logic                  w_pronto_prox;
  logic                  w_fim_fase;
  logic                  w_start_ok;
  logic                  w_ultimo_bit;
  logic [7:0]            w_checksum;
  logic [QUADRO_W-1:0]   w_quadro;

  assign dht_bus   = r_puxa_baixo ? 1'b0 : 1'bz;
  assign ocupado   = r_ocupado;
  assign pronto    = r_pronto;
  assign db_estado = 4'(r_estado);

  // Frame payload captured when the start pulse is accepted
  always_comb begin
    w_checksum = umidade[15:8] + umidade[7:0] + temperatura[15:8] + temperatura[7:0];
`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
    w_checksum[0] = w_checksum[0] ^ corrompe_checksum;
`endif
  end

  assign w_quadro = {umidade, temperatura, w_checksum};

  // Last cycle count of the current timed phase
  always_comb begin
    w_dur_m1 = '0;
    case (r_estado)
      ATRASO:                 w_dur_m1 = CONT_W'(N_ATRASO - 1);
      RESP_BAIXO, RESP_ALTO:  w_dur_m1 = CONT_W'(N_RESP - 1);
      BIT_BAIXO, FIM_BAIXO:   w_dur_m1 = CONT_W'(N_BAIXO - 1);
      BIT_ALTO:               w_dur_m1 = r_shift[QUADRO_W-1] ? CONT_W'(N_BIT1 - 1)
                                                             : CONT_W'(N_BIT0 - 1);
      default:                w_dur_m1 = '0;
    endcase
  end

  assign w_fim_fase   = (r_cont == w_dur_m1);
  assign w_start_ok   = (r_cont >= CONT_W'(N_START - 1));
  assign w_ultimo_bit = (r_nbits >= NBITS_W'(QUADRO_W - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado <= OCIOSO;
    else        r_estado <= w_estado_prox;
  end

  // Line is ignored once the response has started; only habilita can abort it
  always_comb begin
    w_estado_prox = r_estado;
    case (r_estado)
      OCIOSO:     if (habilita && !r_bus_s) w_estado_prox = MEDE_START;
      MEDE_START: if (r_bus_s) w_estado_prox = w_start_ok ? ATRASO : OCIOSO;
      ATRASO:     if (w_fim_fase) w_estado_prox = RESP_BAIXO;
      RESP_BAIXO: if (w_fim_fase) w_estado_prox = RESP_ALTO;
      RESP_ALTO:  if (w_fim_fase) w_estado_prox = BIT_BAIXO;
      BIT_BAIXO:  if (w_fim_fase) w_estado_prox = BIT_ALTO;
      BIT_ALTO:   if (w_fim_fase) w_estado_prox = w_ultimo_bit ? FIM_BAIXO : BIT_BAIXO;
      FIM_BAIXO:  if (w_fim_fase) w_estado_prox = FIM;
      FIM:        w_estado_prox = OCIOSO;
      default:    w_estado_prox = OCIOSO;
    endcase
    if (!habilita && (r_estado != OCIOSO)) w_estado_prox = OCIOSO;
  end

  always_comb begin
    w_puxa_prox    = 1'b0;
    w_ocupado_prox = 1'b0;
    w_pronto_prox  = 1'b0;
    case (w_estado_prox)
      RESP_BAIXO, BIT_BAIXO, FIM_BAIXO: begin
        w_puxa_prox    = 1'b1;
        w_ocupado_prox = 1'b1;
      end
      ATRASO, RESP_ALTO, BIT_ALTO: w_ocupado_prox = 1'b1;
      FIM: begin
        w_ocupado_prox = 1'b1;
        w_pronto_prox  = 1'b1;
      end
      default: ;
    endcase
  end

  // Synchronizer, phase counter, frame shifter and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1      <= 1'b1;
      r_bus_s      <= 1'b1;
      r_cont       <= '0;
      r_shift      <= '0;
      r_nbits      <= '0;
      r_puxa_baixo <= 1'b0;
      r_ocupado    <= 1'b0;
      r_pronto     <= 1'b0;
    end else begin
      r_sync1      <= dht_bus;
      r_bus_s      <= r_sync1;
      r_puxa_baixo <= w_puxa_prox;
      r_ocupado    <= w_ocupado_prox;
      r_pronto     <= w_pronto_prox;

      if (w_estado_prox != r_estado)       r_cont <= '0;
      else if (r_cont != {CONT_W{1'b1}})   r_cont <= r_cont + CONT_W'(1);

      if ((r_estado == MEDE_START) && (w_estado_prox == ATRASO)) begin
        r_shift <= w_quadro;
        r_nbits <= '0;
      end else if ((r_estado == BIT_ALTO) && w_fim_fase && (w_estado_prox != OCIOSO)) begin
        r_shift <= {r_shift[QUADRO_W-2:0], 1'b0};
        if (r_nbits != NBITS_W'(QUADRO_W)) r_nbits <= r_nbits + NBITS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dht11_emulador.sv
// Bench for dht11_emulador: a host-side stimulus plus a waveform model built from the frame rules.
module tb_dht11_emulador;
  localparam int unsigned C   = 1;
  localparam int unsigned TS  = 100;
  localparam int unsigned TB0 = 26;
  localparam int unsigned TB1 = 70;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        habilita = 1'b0;
  logic        host_low = 1'b0;
  logic        corrompe = 1'b0;
  logic [15:0] umidade = 16'h0000;
  logic [15:0] temperatura = 16'h0000;
  wire         dht_bus;
  logic        ocupado;
  logic        pronto;
  logic [3:0]  db_estado;

  pullup (dht_bus);
  assign dht_bus = host_low ? 1'b0 : 1'bz;

  dht11_emulador #(
    .CICLOS_US (C),
    .T_START_US(TS),
    .T_BIT0_US (TB0),
    .T_BIT1_US (TB1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .dht_bus    (dht_bus),
    .umidade    (umidade),
    .temperatura(temperatura),
    .habilita   (habilita),
`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
    .corrompe_checksum(corrompe),
`endif
    .ocupado    (ocupado),
    .pronto     (pronto),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_err = 0;
  bit          exp_bus[$];
  bit          exp_pronto[$];
  bit          mdl_ativo = 1'b0;
  int          t0 = 0;
  int          ocup_cnt = 0;
  int          pronto_cnt = 0;
  int          run = 0;
  int          rx_bits = 0;
  logic [39:0] rx_data = '0;
  logic [39:0] q_atual = '0;

  task automatic chk(input string nome, input logic [63:0] obtido, input logic [63:0] esperado);
    n_checks++;
    if (obtido !== esperado) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nome, cyc, obtido, esperado);
    end
  endtask

  function automatic logic [39:0] quadro(input logic [15:0] u, input logic [15:0] t, input logic c);
    int s;
    s = (int'(u[15:8]) + int'(u[7:0]) + int'(t[15:8]) + int'(t[7:0])) % 256;
    if (c) s = s ^ 1;
    return {u, t, 8'(s)};
  endfunction

  task automatic empilha(input bit nivel, input int n, input bit p);
    for (int i = 0; i < n; i++) begin
      exp_bus.push_back(nivel);
      exp_pronto.push_back(p);
    end
  endtask

  // Expected line level, one entry per cycle from ATRASO entry to the pronto cycle
  task automatic monta_modelo(input logic [39:0] q);
    exp_bus.delete();
    exp_pronto.delete();
    empilha(1'b1, 30 * C, 1'b0);
    empilha(1'b0, 80 * C, 1'b0);
    empilha(1'b1, 80 * C, 1'b0);
    for (int b = 39; b >= 0; b--) begin
      empilha(1'b0, 50 * C, 1'b0);
      empilha(1'b1, (q[b] ? TB1 : TB0) * C, 1'b0);
    end
    empilha(1'b0, 50 * C, 1'b0);
    empilha(1'b1, 1, 1'b1);
  endtask

  task automatic passo(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic espera_ate(input int n);
    while (cyc < n) begin @(posedge clock); #1; end
  endtask

  task automatic host_start(input int w);
    ocup_cnt = 0; pronto_cnt = 0; rx_bits = 0; rx_data = '0;
    host_low = 1'b1;
    passo(w);
    host_low = 1'b0;
    if ((w >= int'(TS * C)) && habilita && reset) begin
      t0 = cyc + 1 + 2;
      q_atual = quadro(umidade, temperatura, corrompe);
      monta_modelo(q_atual);
      mdl_ativo = 1'b1;
    end
  endtask

  task automatic espera_fim();
    int i;
    i = 0;
    while (mdl_ativo && i < 20000) begin @(posedge clock); #1; i++; end
    chk("frame_timeout", 64'(mdl_ativo), 64'd0);
    mdl_ativo = 1'b0;
    exp_bus.delete();
    exp_pronto.delete();
    passo(20);
  endtask

  task automatic aborta_modelo();
    mdl_ativo = 1'b0;
    exp_bus.delete();
    exp_pronto.delete();
  endtask

  task automatic confere_quadro(input logic [39:0] dados, input int comprimento);
    chk("rx_bits", 64'(rx_bits), 64'd40);
    chk("rx_data", 64'(rx_data), 64'(dados));
    chk("frame_len", 64'(ocup_cnt), 64'(comprimento));
    chk("pronto_pulses", 64'(pronto_cnt), 64'd1);
    chk("estado_final", 64'(db_estado), 64'd0);
  endtask

  initial begin
    int off;
    fork
      forever begin
        bit eb, ep;
        @(negedge clock);
        if (ocupado === 1'b1) ocup_cnt++;
        if (pronto === 1'b1) pronto_cnt++;
        if (dht_bus === 1'b1) run++;
        else begin
          if (run == int'(TB0 * C)) begin rx_data = {rx_data[38:0], 1'b0}; rx_bits++; end
          else if (run == int'(TB1 * C)) begin rx_data = {rx_data[38:0], 1'b1}; rx_bits++; end
          run = 0;
        end
        if (mdl_ativo && cyc >= t0) begin
          if (exp_bus.size() > 0) begin
            eb = exp_bus.pop_front();
            ep = exp_pronto.pop_front();
            chk("bus", 64'(dht_bus), 64'(eb));
            chk("ocupado", 64'(ocupado), 64'd1);
            chk("pronto", 64'(pronto), 64'(ep));
          end
          if (exp_bus.size() == 0) mdl_ativo = 1'b0;
        end else begin
          chk("bus_idle", 64'(dht_bus), 64'(!host_low));
          chk("ocupado_idle", 64'(ocupado), 64'd0);
          chk("pronto_idle", 64'(pronto), 64'd0);
        end
      end
    join_none

    passo(3);
    chk("rst_estado", 64'(db_estado), 64'd0);
    chk("rst_ocupado", 64'(ocupado), 64'd0);
    chk("rst_pronto", 64'(pronto), 64'd0);
    chk("rst_bus", 64'(dht_bus), 64'd1);
    reset = 1'b1;
    habilita = 1'b1;
    passo(10);

    // 12 ones / 28 zeros: 190 + 2000 + 12*70 + 28*26 + 50 + 1
    umidade = 16'h3A00; temperatura = 16'h1905;
    host_start(100);
    espera_fim();
    confere_quadro(40'h3A00190558, 3809);

    host_start(60);
    passo(200);
    chk("glitch60_ocup", 64'(ocup_cnt), 64'd0);
    chk("glitch60_estado", 64'(db_estado), 64'd0);
    host_start(99);
    passo(200);
    chk("glitch99_ocup", 64'(ocup_cnt), 64'd0);
    chk("glitch99_pronto", 64'(pronto_cnt), 64'd0);

    // Asynchronous reset in BIT_ALTO of bit 17
    host_start(100);
    off = 190;
    for (int m = 0; m < 17; m++) off += 50 * C + (q_atual[39 - m] ? TB1 : TB0) * C;
    off += 50 * C + 5;
    espera_ate(t0 + off);
    chk("bit17_estado", 64'(db_estado), 64'd6);
    reset = 1'b0;
    aborta_modelo();
    #1;
    chk("arst_bus", 64'(dht_bus), 64'd1);
    chk("arst_ocupado", 64'(ocupado), 64'd0);
    chk("arst_estado", 64'(db_estado), 64'd0);
    passo(5);
    reset = 1'b1;
    passo(10);
    host_start(100);
    espera_fim();
    confere_quadro(40'h3A00190558, 3809);

    // 38 ones, checksum wraps to FC: 190 + 2000 + 38*70 + 2*26 + 50 + 1
    umidade = 16'hFFFF; temperatura = 16'hFFFF;
    host_start(100);
    espera_fim();
    confere_quadro(40'hFFFFFFFFFC, 4953);

    habilita = 1'b0;
    host_start(100);
    passo(300);
    chk("hab0_ocup", 64'(ocup_cnt), 64'd0);
    chk("hab0_pronto", 64'(pronto_cnt), 64'd0);
    habilita = 1'b1;
    passo(10);

    // habilita dropped in the middle of RESP_BAIXO
    umidade = 16'h3A00; temperatura = 16'h1905;
    host_start(100);
    espera_ate(t0 + 40);
    chk("resp_baixo_bus", 64'(dht_bus), 64'd0);
    chk("resp_baixo_estado", 64'(db_estado), 64'd3);
    habilita = 1'b0;
    passo(1);
    aborta_modelo();
    passo(300);
    chk("drop_pronto", 64'(pronto_cnt), 64'd0);
    chk("drop_ocup_len", 64'(ocup_cnt), 64'd41);
    chk("drop_estado", 64'(db_estado), 64'd0);
    habilita = 1'b1;
    passo(20);

`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
    // Corrupted checksum 59 has one extra one: 190 + 2000 + 13*70 + 27*26 + 50 + 1
    corrompe = 1'b1;
    host_start(100);
    espera_fim();
    confere_quadro(40'h3A00190559, 3853);
    corrompe = 1'b0;
    passo(10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
